// File: rtl/mutative_types.sv
// Shared types and constants for the cache-to-memory path.
package mutative_types;

    // Byte offset bits inside one 32-byte cache line.
    localparam int OFFSET_BITS = 5;

    // Line and memory beat geometry.
    localparam int LINE_WIDTH  = 256;
    localparam int BEAT_WIDTH  = 64;
    localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_WIDTH   = $clog2(BEATS);
    localparam int BEAT_SHIFT  = $clog2(BEAT_WIDTH);
    localparam int LINE_IDX_W  = $clog2(LINE_WIDTH);

    // Line adapter control states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_DATA  = 3'd2,
        WR_BURST = 3'd3,
        RESP     = 3'd4
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts 256-bit cache line fills / write-backs into 4-beat 64-bit bursts.
// All outputs are decoded from registered state and captured data only, so
// nothing on dfp_* reaches bmem_* combinationally.
module cacheline_adapter
    import mutative_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic [31:0]           bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);

    adapter_state_t          r_state;
    adapter_state_t          w_next_state;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [31:0]             r_addr;
    logic [LINE_WIDTH-1:0]   r_line;
    logic [LINE_WIDTH-1:0]   r_wbuf;
    logic [LINE_IDX_W-1:0]   w_beat_base;
    logic                    w_take_wr;
    logic                    w_take_rd;
    logic                    w_rd_beat;
    logic                    w_wr_beat;
    logic                    w_last_beat;
    logic                    w_unused_offset;

    // Offset bits of the line address are intentionally dropped.
    assign w_unused_offset = ^dfp_addr[OFFSET_BITS-1:0];

    // Bit position of the current beat within the line.
    assign w_beat_base = {r_cnt, {BEAT_SHIFT{1'b0}}};
    assign w_last_beat = (r_cnt == CNT_WIDTH'(BEATS - 1));

    // Next-state decode; a pending write always wins over a pending read.
    always_comb begin
        w_next_state = r_state;
        w_take_wr    = 1'b0;
        w_take_rd    = 1'b0;
        w_rd_beat    = 1'b0;
        w_wr_beat    = 1'b0;
        case (r_state)
            IDLE: begin
                if (dfp_write) begin
                    w_take_wr    = 1'b1;
                    w_next_state = WR_BURST;
                end else if (dfp_read) begin
                    w_take_rd    = 1'b1;
                    w_next_state = RD_REQ;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    w_next_state = RD_DATA;
                end else begin
                    w_next_state = RD_REQ;
                end
            end
            RD_DATA: begin
                if (bmem_rvalid) begin
                    w_rd_beat    = 1'b1;
                    w_next_state = w_last_beat ? RESP : RD_DATA;
                end else begin
                    w_next_state = RD_DATA;
                end
            end
            WR_BURST: begin
                if (bmem_ready) begin
                    w_wr_beat    = 1'b1;
                    w_next_state = w_last_beat ? RESP : WR_BURST;
                end else begin
                    w_next_state = WR_BURST;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Beat counter, captured address, write buffer and assembled fill line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_wbuf <= '0;
            r_line <= '0;
        end else begin
            if (w_take_wr || w_take_rd) begin
                r_cnt  <= '0;
                r_addr <= {dfp_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            end else if (w_rd_beat || w_wr_beat) begin
                r_cnt  <= r_cnt + CNT_WIDTH'(1);
            end
            if (w_take_wr) begin
                r_wbuf <= dfp_wdata;
            end
            if (w_rd_beat) begin
                r_line[w_beat_base +: BEAT_WIDTH] <= bmem_rdata;
            end
        end
    end

    assign dfp_rdata  = r_line;
    assign dfp_resp   = (r_state == RESP);
    assign bmem_addr  = r_addr;
    assign bmem_read  = (r_state == RD_REQ);
    assign bmem_write = (r_state == WR_BURST);
    assign bmem_wdata = r_wbuf[w_beat_base +: BEAT_WIDTH];

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Bridges the cache's 256-bit line-granular downstream port (dfp_*) to a 64-bit burst memory (bmem_*). Each line fill or write-back becomes one 4-beat burst. Beats are packed into a line on reads and split from the line on writes. The block sits directly below the cache, with one instance per cache, and is the only path from the cache to memory.

## Interface
- LINE_WIDTH, 256: dfp data width in bits.
- BEAT_WIDTH, 64: bmem data width in bits. BEATS = LINE_WIDTH/BEAT_WIDTH = 4.
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- dfp_addr  in  32  line address; bits [4:0] ignored.
- dfp_read  in  1  line fill request; held until dfp_resp.
- dfp_write  in  1  write-back request; held until dfp_resp.
- dfp_wdata  in  256  write-back line; stable while dfp_write is high.
- dfp_rdata  out  256  assembled fill line.
- dfp_resp  out  1  single-cycle completion pulse.
- bmem_addr  out  32  burst address, {dfp_addr[31:5], 5'b0}.
- bmem_read  out  1  read burst command.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  64  write beat.
- bmem_ready  in  1  memory accepts the command or beat this cycle.
- bmem_rdata  in  64  read beat.
- bmem_rvalid  in  1  read beat valid; beats arrive in order 0..3 and may have gaps.

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_BURST, RESP. Beat counter cnt is 2 bits.
- IDLE, dfp_write=1: capture address, load the line into the write buffer, cnt=0, go to WR_BURST.
- IDLE, dfp_read=1 and dfp_write=0: capture address, cnt=0, go to RD_REQ.
- IDLE, both requests high: the write is serviced first. The read is taken on a later IDLE cycle if it is still held.
- RD_REQ: bmem_read=1 with bmem_addr. Stay until bmem_ready=1, then go to RD_DATA.
- RD_DATA: on each bmem_rvalid, store bmem_rdata into line bits [64*cnt +: 64] and increment cnt. On the beat with cnt=3, go to RESP.
- WR_BURST: bmem_write=1, bmem_wdata = buffer[64*cnt +: 64]. Increment cnt on each cycle with bmem_ready=1. On acceptance with cnt=3, go to RESP. With bmem_ready=0, address and beat are held.
- RESP: dfp_resp=1 for exactly one cycle, then go to IDLE. After a read, dfp_rdata is the full line during this cycle.
- dfp_rdata is the line register itself. It holds its value until the first beat of the next read overwrites it.
- bmem_rvalid outside RD_DATA is ignored.
- The address and write data are captured at acceptance. Later changes on dfp_* do not affect a burst in flight.
- Reset in any state: state goes to IDLE, cnt to 0, the transaction is dropped, no dfp_resp is issued.

## Timing
- Reset values: dfp_resp=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0, dfp_rdata=0.
- All outputs are driven from registered state and captured data. No combinational path from dfp_* to bmem_*.
- Read, request seen in cycle N:
  - bmem_read is high from N+1 until it is accepted.
  - If accepted in N+1 and beats arrive at N+2..N+5, dfp_resp is high in N+6.
- Write, request seen in cycle N:
  - Beats occupy cycles N+1..N+4 when bmem_ready is always high.
  - dfp_resp is high in N+5.
- The first new request is accepted the cycle after RESP, since IDLE samples it. A request held through RESP is therefore not serviced twice.
- cnt wraps from 3 to 0 only on the state exit.

## Structure
- Add to mutative_types: LINE_WIDTH, BEAT_WIDTH, BEATS, and adapter_state_t (enum of the five states).
- Reuse OFFSET_BITS from mutative_types for address alignment.
- Single module. No sub-module is natural; the 256-bit line register and 256-bit write buffer are local registers.

## Test plan
- Read, memory always ready, beats 64'h0..0011, 64'h..22, 64'h..33, 64'h..44 in consecutive cycles, dfp_addr=32'h0000_1234:
  - bmem_addr = 32'h0000_1220.
  - One dfp_resp pulse, 6 cycles after the request.
  - dfp_rdata = {beat3, beat2, beat1, beat0}.
- Write, line 256'h(4{64'hA5A5_..._0000 + beat index}), bmem_ready deasserted for 2 cycles on beat 2:
  - Exactly 4 accepted beats, in order.
  - The stalled beat is held unchanged.
  - dfp_resp 7 cycles after the request.
- Read with rvalid gaps (beats at +0, +3, +4, +9 after acceptance):
  - Correct line assembly.
  - dfp_resp only after the 4th beat.
  - Stray rvalid in IDLE leaves dfp_rdata unchanged.
- Write-back followed immediately by fill (the cache's eviction sequence):
  - Write completes first, then one read burst.
  - Exactly two dfp_resp pulses.
  - No bmem_read during the write burst.
- rst asserted mid-WR_BURST after beat 1:
  - Next cycle all outputs are 0 and state is IDLE, with no dfp_resp.
  - A subsequent read completes normally.
- dfp_read and dfp_write both high in IDLE:
  - The write burst is issued first, to the same bmem_addr.
